// File: rtl/plic_agent_pkg.sv
// Shared definitions for the external-interrupt controller: register offsets,
// word indices used by the decoder, and the gateway state encoding.
package plic_agent_pkg;

  localparam logic [7:0] PLIC_PRIO_BASE = 8'h00;
  localparam logic [7:0] PLIC_PENDING   = 8'h80;
  localparam logic [7:0] PLIC_ENABLE    = 8'h84;
  localparam logic [7:0] PLIC_THRESHOLD = 8'h88;
  localparam logic [7:0] PLIC_CLAIM     = 8'h8C;

  // Source IDs are 1..31, so five bits always suffice.
  localparam int ID_W = 5;

  localparam logic [5:0] IDX_PRIO_BASE = PLIC_PRIO_BASE[7:2];
  localparam logic [5:0] IDX_PENDING   = PLIC_PENDING[7:2];
  localparam logic [5:0] IDX_ENABLE    = PLIC_ENABLE[7:2];
  localparam logic [5:0] IDX_THRESHOLD = PLIC_THRESHOLD[7:2];
  localparam logic [5:0] IDX_CLAIM     = PLIC_CLAIM[7:2];

  typedef enum logic [1:0] {
    GW_IDLE     = 2'd0,
    GW_PENDING  = 2'd1,
    GW_INFLIGHT = 2'd2
  } gw_state_e;

  // Word index of a byte offset within the 256-byte register window.
  function automatic logic [5:0] word_idx(input logic [7:0] offset);
    return offset[7:2];
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: two-flop synchronizer for the raw level followed by the
// IDLE/PENDING/INFLIGHT state machine. The state itself is the output.
module plic_gateway
  import plic_agent_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irq,
  input  logic       claim,
  input  logic       complete,
  output logic [1:0] state
);

  logic      sync1;
  logic      sync2;
  gw_state_e st;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      st    <= GW_IDLE;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      case (st)
        GW_IDLE:     if (sync2)    st <= GW_PENDING;
        // A falling level while pending is deliberately not observed.
        GW_PENDING:  if (claim)    st <= GW_INFLIGHT;
        GW_INFLIGHT: if (complete) st <= GW_IDLE;
        default:                   st <= GW_IDLE;
      endcase
    end
  end

  assign state = st;

endmodule

// File: rtl/plic_agent.sv
// External-interrupt controller: register file, priority arbiter and bus
// front end around NUM_SRC gateways; meip feeds the interrupt agent.
module plic_agent
  import plic_agent_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3,
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SRC-1:0] plic_i_irq_src,
  input  logic              plic_i_exu_valid,
  input  logic              plic_i_exu_wr,
  input  logic              plic_i_exu_rd,
  input  logic [ADDR_W-1:0] plic_i_exu_addr,
  input  logic [XLEN-1:0]   plic_i_exu_wdata,
  output logic [XLEN-1:0]   plic_o_exu_rdata,
  output logic              plic_o_exu_ready,
  output logic              plic_o_meip
);

  // Bus handshake: a request is taken on an edge with valid=1 and ready=0;
  // every side effect commits on that edge, and ready/rdata follow for exactly
  // one cycle. valid seen during the ready cycle is never a new request.

  logic [PRIO_W-1:0] prio [1:NUM_SRC];
  logic [NUM_SRC:0]  enable;
  logic [PRIO_W-1:0] threshold;
  logic [NUM_SRC:0]  pend_vec;
  logic [1:0]        gw_state [1:NUM_SRC];

  logic              ready_q;
  logic [XLEN-1:0]   rdata_q;
  logic              meip_q;

  logic              accept;
  logic              is_wr;
  logic              is_rd;
  logic [5:0]        idx;
  logic [ID_W-1:0]   cpl_id;
  logic [ID_W-1:0]   best_id;
  logic [PRIO_W-1:0] best_prio;
  logic [NUM_SRC:0]  claim_vec;
  logic [NUM_SRC:0]  complete_vec;
  logic [XLEN-1:0]   rd_val;
  logic              unused_bits;

  assign accept = plic_i_exu_valid & ~ready_q;
  assign is_wr  = accept & plic_i_exu_wr;
  // Requests carrying both wr and rd behave as writes.
  assign is_rd  = accept & plic_i_exu_rd & ~plic_i_exu_wr;
  assign idx    = plic_i_exu_addr[7:2];
  assign cpl_id = plic_i_exu_wdata[ID_W-1:0];

  // Only addr[7:2] and the low data bits are meaningful.
  assign unused_bits = ^{plic_i_exu_addr, plic_i_exu_wdata};

  assign pend_vec[0] = 1'b0;

  for (genvar g = 1; g <= NUM_SRC; g++) begin : g_gw
    plic_gateway u_gw (
      .clk      (clk),
      .rst_n    (rst_n),
      .irq      (plic_i_irq_src[g-1]),
      .claim    (claim_vec[g]),
      .complete (complete_vec[g]),
      .state    (gw_state[g])
    );
    assign pend_vec[g] = (gw_state[g] == GW_PENDING);
  end

  // Strict '>' while scanning upward makes the lowest ID win a priority tie.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (pend_vec[i] && enable[i] && (prio[i] > threshold) && (prio[i] > best_prio)) begin
        best_id   = ID_W'(i);
        best_prio = prio[i];
      end
    end
  end

  // Complete of an ID that is not inflight is dropped inside the gateway.
  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (is_rd && (idx == IDX_CLAIM) && (best_id == ID_W'(i)))
        claim_vec[i] = 1'b1;
      if (is_wr && (idx == IDX_CLAIM) && (cpl_id == ID_W'(i)))
        complete_vec[i] = 1'b1;
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (idx == (IDX_PRIO_BASE + 6'(i)))
        rd_val[PRIO_W-1:0] = prio[i];
    end
    case (idx)
      IDX_PENDING:   rd_val = XLEN'(pend_vec);
      IDX_ENABLE:    rd_val = XLEN'(enable);
      IDX_THRESHOLD: rd_val = XLEN'(threshold);
      IDX_CLAIM:     rd_val = XLEN'(best_id);
      default:       ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i <= NUM_SRC; i++) prio[i] <= '0;
      enable    <= '0;
      threshold <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      meip_q    <= 1'b0;
    end else begin
      ready_q <= accept;
      rdata_q <= is_rd ? rd_val : '0;
      meip_q  <= (best_id != '0);
      if (is_wr) begin
        for (int i = 1; i <= NUM_SRC; i++) begin
          if (idx == (IDX_PRIO_BASE + 6'(i)))
            prio[i] <= plic_i_exu_wdata[PRIO_W-1:0];
        end
        if (idx == IDX_ENABLE)
          enable <= {plic_i_exu_wdata[NUM_SRC:1], 1'b0};
        if (idx == IDX_THRESHOLD)
          threshold <= plic_i_exu_wdata[PRIO_W-1:0];
      end
    end
  end

  // Holding reset masks a completion that was already registered, so a
  // transaction cut by reset never shows a ready pulse.
  assign plic_o_exu_ready = ready_q & rst_n;
  assign plic_o_exu_rdata = rdata_q & {XLEN{plic_o_exu_ready}};
  assign plic_o_meip      = meip_q;

endmodule

// File: tb/tb_plic_agent.sv
// Directed bench for plic_agent: bus reads push expected data to a queue that
// is popped and compared when the ready pulse arrives.
module tb_plic_agent;

  localparam int NUM_SRC = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [NUM_SRC-1:0] irq_src = '0;
  logic        valid = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        meip;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  plic_agent #(.NUM_SRC(NUM_SRC), .PRIO_W(3), .XLEN(32), .ADDR_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .plic_i_irq_src   (irq_src),
    .plic_i_exu_valid (valid),
    .plic_i_exu_wr    (wr),
    .plic_i_exu_rd    (rd),
    .plic_i_exu_addr  (addr),
    .plic_i_exu_wdata (wdata),
    .plic_o_exu_rdata (rdata),
    .plic_o_exu_ready (ready),
    .plic_o_meip      (meip)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: one request, valid dropped after the accept edge, bounded wait for ready.
  task automatic xfer(input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] d, input string tag, output logic [31:0] data);
    int n;
    @(negedge clk);
    valid = 1'b1; wr = w; rd = r; addr = a; wdata = d;
    @(posedge clk);
    #1;
    valid = 1'b0; wr = 1'b0; rd = 1'b0;
    @(negedge clk);
    n = 0;
    while (!ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(ready), 32'd1);
    data = rdata;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input string tag);
    logic [31:0] dummy;
    xfer(1'b1, 1'b0, a, d, tag, dummy);
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] got;
    exp_q.push_back(exp);
    xfer(1'b0, 1'b1, a, 32'd0, tag, got);
    check(tag, got, exp_q.pop_front());
  endtask

  task automatic do_reset();
    irq_src = '0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] tmp;

    // 1. reset values
    repeat (3) @(negedge clk);
    check("t1_rst_ready", 32'(ready), 32'd0);
    check("t1_rst_meip", 32'(meip), 32'd0);
    rst_n = 1'b1;
    bus_rd(32'h80, 32'h0, "t1_pending");
    bus_rd(32'h84, 32'h0, "t1_enable");
    bus_rd(32'h88, 32'h0, "t1_threshold");
    bus_rd(32'h8C, 32'h0, "t1_claim");
    check("t1_meip", 32'(meip), 32'd0);

    // 2. single source latency, claim, complete with level still high
    bus_wr(32'h0C, 32'd2, "t2_prio3");
    bus_wr(32'h84, 32'h08, "t2_enable");
    bus_wr(32'h88, 32'd0, "t2_thresh");
    @(negedge clk);
    irq_src[2] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("t2_meip_early", 32'(meip), 32'd0);
    end
    @(negedge clk);
    check("t2_meip_edge4", 32'(meip), 32'd1);
    bus_rd(32'h80, 32'h08, "t2_pending");
    bus_rd(32'h8C, 32'd3, "t2_claim");
    check("t2_meip_accept_cycle", 32'(meip), 32'd1);
    @(negedge clk);
    check("t2_meip_after_claim", 32'(meip), 32'd0);
    bus_rd(32'h80, 32'h0, "t2_pending_clr");
    bus_wr(32'h8C, 32'd3, "t2_complete");
    bus_rd(32'h80, 32'h08, "t2_repend");
    @(negedge clk);
    check("t2_meip_repend", 32'(meip), 32'd1);

    // 3. priority and tie-break
    do_reset();
    bus_wr(32'h08, 32'd4, "t3_prio2");
    bus_wr(32'h14, 32'd4, "t3_prio5");
    bus_wr(32'h84, 32'h24, "t3_enable");
    irq_src = 8'b0001_0010;
    repeat (5) @(negedge clk);
    bus_rd(32'h80, 32'h24, "t3_pending");
    bus_rd(32'h8C, 32'd2, "t3_tie_claim");
    bus_wr(32'h14, 32'd6, "t3_prio5_up");
    bus_rd(32'h8C, 32'd5, "t3_prio_claim");
    bus_rd(32'h8C, 32'd0, "t3_drained_claim");

    // 4. threshold and enable masking
    do_reset();
    bus_wr(32'h04, 32'd3, "t4_prio1");
    bus_wr(32'h88, 32'd3, "t4_thresh3");
    bus_wr(32'h84, 32'h02, "t4_enable");
    irq_src = 8'h01;
    repeat (6) @(negedge clk);
    check("t4_meip_masked", 32'(meip), 32'd0);
    bus_rd(32'h80, 32'h02, "t4_pending");
    bus_wr(32'h88, 32'd2, "t4_thresh2");
    @(negedge clk);
    check("t4_meip_thresh2", 32'(meip), 32'd1);
    bus_wr(32'h84, 32'h0, "t4_disable");
    @(negedge clk);
    check("t4_meip_disabled", 32'(meip), 32'd0);
    bus_rd(32'h80, 32'h02, "t4_pending_kept");

    // 5. invalid completes, empty claim, map corners
    bus_wr(32'h8C, 32'd0, "t5_cpl0");
    bus_wr(32'h8C, 32'(NUM_SRC + 1), "t5_cpl_oor");
    bus_wr(32'h8C, 32'd1, "t5_cpl_not_inflight");
    bus_rd(32'h80, 32'h02, "t5_pending_after_cpl");
    bus_rd(32'h8C, 32'd0, "t5_empty_claim");
    bus_rd(32'h80, 32'h02, "t5_pending_after_claim");
    bus_wr(32'h84, 32'hFFFF_FFFF, "t5_enable_all");
    bus_rd(32'h84, 32'h0000_01FE, "t5_enable_mask");
    bus_rd(32'h04, 32'd3, "t5_prio1_rb");
    bus_rd(32'h00, 32'd0, "t5_prio0_ro");
    bus_wr(32'h80, 32'hFF, "t5_pending_ro_wr");
    bus_rd(32'h80, 32'h02, "t5_pending_ro");
    bus_rd(32'h90, 32'd0, "t5_unmapped");
    xfer(1'b1, 1'b1, 32'h88, 32'd5, "t5_wr_rd", tmp);
    bus_rd(32'h88, 32'd5, "t5_wr_rd_thresh");
    bus_wr(32'h88, 32'd2, "t5_thresh_restore");
    repeat (2) @(negedge clk);
    check("t5_meip_on", 32'(meip), 32'd1);

    // 6. reset on the cycle after a claim accept
    @(negedge clk);
    valid = 1'b1; rd = 1'b1; wr = 1'b0; addr = 32'h8C;
    @(posedge clk);
    #1;
    valid = 1'b0; rd = 1'b0; rst_n = 1'b0; irq_src = '0;
    @(negedge clk);
    check("t6_no_ready", 32'(ready), 32'd0);
    @(negedge clk);
    check("t6_no_ready_late", 32'(ready), 32'd0);
    check("t6_meip", 32'(meip), 32'd0);
    rst_n = 1'b1;
    bus_rd(32'h80, 32'h0, "t6_pending");
    bus_rd(32'h84, 32'h0, "t6_enable");
    bus_rd(32'h88, 32'h0, "t6_threshold");
    bus_rd(32'h04, 32'h0, "t6_prio1");
    bus_rd(32'h8C, 32'h0, "t6_claim");
    check("t6_meip_after", 32'(meip), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
